node_route_sequencer: RTL and testbench

Sequences the line-following bot's route across the arena. It watches the thresholded line-sensor pattern and confirms node crossings (all three sensors on black). At each node it looks up the programmed action, then drives a command to the motor-control datapath: follow line, turn right, turn left or halt. It also counts nodes and laps and raises `finish` when the run is complete.

---
 rtl/node_route_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_node_route_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/node_route_sequencer.sv
// Route sequencer for the line-following bot: confirms node crossings, applies the per-node action, counts nodes/laps.
// Define NODE_ROUTE_WRITE_EN to make the route table writable in IDLE; otherwise it is the constant ROUTE_INIT.
module node_route_sequencer #(
  parameter int unsigned NODES_PER_LAP = 8,
  parameter int unsigned LAPS          = 2,
  parameter int unsigned NODE_CONFIRM  = 4,
  parameter int unsigned BLANK_CYCLES  = 7812500,
  parameter int unsigned TURN_MIN      = 1562500,
  parameter logic [15:0] ROUTE_INIT    = 16'h1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] ld,
  input  logic       route_wr_en,
  input  logic [2:0] route_wr_addr,
  input  logic [1:0] route_wr_data,
  output logic [1:0] cmd,
  output logic       node_detected,
  output logic [3:0] node_counter,
  output logic [1:0] lap_counter,
  output logic       finish
);

  localparam int unsigned CONF_W = (NODE_CONFIRM > 2) ? $clog2(NODE_CONFIRM) : 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(NODE_CONFIRM - 1);
  localparam logic [3:0]  NODE_LAST  = 4'(NODES_PER_LAP - 1);
  localparam logic [1:0]  LAP_TARGET = 2'(LAPS);
  localparam logic [23:0] TURN_LAST  = 24'(TURN_MIN - 1);
  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

  localparam logic [1:0] CMD_FOLLOW   = 2'b00;
  localparam logic [1:0] CMD_HALT     = 2'b11;
  localparam logic [1:0] ACT_STRAIGHT = 2'b00;
  localparam logic [1:0] ACT_HALT     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_TURN   = 3'd2,
    ST_BLANK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               start_q_r, start_armed_r, start_edge_s;
  logic [CONF_W-1:0]  confirm_r, confirm_nxt_s;
  logic [23:0]        turn_cnt_r, turn_cnt_nxt_s;
  logic [23:0]        blank_cnt_r, blank_cnt_nxt_s;
  logic [1:0]         cmd_r, cmd_nxt_s;
  logic               node_detected_r, node_detected_nxt_s;
  logic [3:0]         node_counter_r, node_counter_nxt_s;
  logic [1:0]         lap_counter_r, lap_counter_nxt_s, lap_inc_s;
  logic               finish_r, finish_nxt_s;
  logic               route_we_s;
  logic [1:0]         route_rd_s;
  logic               unused_s;

  // The armed flag suppresses a false edge when start is already high as reset releases.
  assign start_edge_s = start & ~start_q_r & start_armed_r;

`ifdef NODE_ROUTE_WRITE_EN
  logic [15:0] route_r;

  // Route table storage, writable only while the sequencer is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      route_r <= ROUTE_INIT;
    end else if (route_we_s) begin
      route_r[{route_wr_addr, 1'b0} +: 2] <= route_wr_data;
    end
  end

  assign route_rd_s = route_r[{node_counter_r[2:0], 1'b0} +: 2];
  assign unused_s   = node_counter_r[3];
`else
  assign route_rd_s = ROUTE_INIT[{node_counter_r[2:0], 1'b0} +: 2];
  assign unused_s   = ^{node_counter_r[3], route_we_s, route_wr_en, route_wr_addr, route_wr_data};
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s         = state_r;
    cmd_nxt_s           = cmd_r;
    node_detected_nxt_s = 1'b0;
    node_counter_nxt_s  = node_counter_r;
    lap_counter_nxt_s   = lap_counter_r;
    finish_nxt_s        = finish_r;
    confirm_nxt_s       = confirm_r;
    turn_cnt_nxt_s      = turn_cnt_r;
    blank_cnt_nxt_s     = blank_cnt_r;
    route_we_s          = 1'b0;
    lap_inc_s           = lap_counter_r + 2'd1;
    case (state_r)
      ST_IDLE: begin
        cmd_nxt_s  = CMD_HALT;
        route_we_s = route_wr_en;
        if (start_edge_s) begin
          state_nxt_s   = ST_FOLLOW;
          cmd_nxt_s     = CMD_FOLLOW;
          confirm_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FOLLOW: begin
        cmd_nxt_s = CMD_FOLLOW;
        if (ld == 3'b111) begin
          if (confirm_r == CONF_LAST) begin
            confirm_nxt_s       = '0;
            node_detected_nxt_s = 1'b1;
            if (node_counter_r == NODE_LAST) begin
              node_counter_nxt_s = 4'd0;
              lap_counter_nxt_s  = lap_inc_s;
            end else begin
              node_counter_nxt_s = node_counter_r + 4'd1;
            end
            if (((node_counter_r == NODE_LAST) && (lap_inc_s == LAP_TARGET)) ||
                (route_rd_s == ACT_HALT)) begin
              state_nxt_s  = ST_DONE;
              cmd_nxt_s    = CMD_HALT;
              finish_nxt_s = 1'b1;
            end else if (route_rd_s == ACT_STRAIGHT) begin
              state_nxt_s     = ST_BLANK;
              blank_cnt_nxt_s = 24'd0;
            end else begin
              state_nxt_s    = ST_TURN;
              turn_cnt_nxt_s = 24'd0;
              cmd_nxt_s      = route_rd_s;
            end
          end else begin
            confirm_nxt_s = confirm_r + CONF_W'(1);
          end
        end else begin
          confirm_nxt_s = '0;
        end
      end
      ST_TURN: begin
        if ((turn_cnt_r >= TURN_LAST) && (ld == 3'b010)) begin
          state_nxt_s     = ST_BLANK;
          blank_cnt_nxt_s = 24'd0;
          cmd_nxt_s       = CMD_FOLLOW;
        end else if (turn_cnt_r < TURN_LAST) begin
          turn_cnt_nxt_s = turn_cnt_r + 24'd1;
        end else begin
          turn_cnt_nxt_s = turn_cnt_r;
        end
      end
      ST_BLANK: begin
        cmd_nxt_s = CMD_FOLLOW;
        if (blank_cnt_r == BLANK_LAST) begin
          state_nxt_s   = ST_FOLLOW;
          confirm_nxt_s = '0;
        end else begin
          blank_cnt_nxt_s = blank_cnt_r + 24'd1;
        end
      end
      ST_DONE: begin
        cmd_nxt_s    = CMD_HALT;
        finish_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cmd_nxt_s   = CMD_HALT;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      start_q_r       <= 1'b0;
      start_armed_r   <= 1'b0;
      confirm_r       <= '0;
      turn_cnt_r      <= 24'd0;
      blank_cnt_r     <= 24'd0;
      cmd_r           <= CMD_HALT;
      node_detected_r <= 1'b0;
      node_counter_r  <= 4'd0;
      lap_counter_r   <= 2'd0;
      finish_r        <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      start_q_r       <= start;
      start_armed_r   <= 1'b1;
      confirm_r       <= confirm_nxt_s;
      turn_cnt_r      <= turn_cnt_nxt_s;
      blank_cnt_r     <= blank_cnt_nxt_s;
      cmd_r           <= cmd_nxt_s;
      node_detected_r <= node_detected_nxt_s;
      node_counter_r  <= node_counter_nxt_s;
      lap_counter_r   <= lap_counter_nxt_s;
      finish_r        <= finish_nxt_s;
    end
  end

  assign cmd           = cmd_r;
  assign node_detected = node_detected_r;
  assign node_counter  = node_counter_r;
  assign lap_counter   = lap_counter_r;
  assign finish        = finish_r;

endmodule

// File: tb/tb_node_route_sequencer.sv
// Directed self-checking bench for node_route_sequencer with shortened blank/turn timers.
module tb_node_route_sequencer;

  logic       clk;
  logic       a_reset, a_start, a_wr_en;
  logic [2:0] a_ld, a_wr_addr;
  logic [1:0] a_wr_data, a_cmd, a_lap;
  logic       a_nd, a_fin;
  logic [3:0] a_nc;

  logic       b_reset, b_start, b_wr_en;
  logic [2:0] b_ld, b_wr_addr;
  logic [1:0] b_wr_data, b_cmd, b_lap;
  logic       b_nd, b_fin;
  logic [3:0] b_nc;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  node_route_sequencer #(
    .NODES_PER_LAP(8), .LAPS(2), .NODE_CONFIRM(4),
    .BLANK_CYCLES(20), .TURN_MIN(5), .ROUTE_INIT(16'h1111)
  ) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .ld(a_ld),
    .route_wr_en(a_wr_en), .route_wr_addr(a_wr_addr), .route_wr_data(a_wr_data),
    .cmd(a_cmd), .node_detected(a_nd), .node_counter(a_nc),
    .lap_counter(a_lap), .finish(a_fin)
  );

  node_route_sequencer #(
    .NODES_PER_LAP(2), .LAPS(2), .NODE_CONFIRM(4),
    .BLANK_CYCLES(20), .TURN_MIN(5), .ROUTE_INIT(16'h0000)
  ) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .ld(b_ld),
    .route_wr_en(b_wr_en), .route_wr_addr(b_wr_addr), .route_wr_data(b_wr_data),
    .cmd(b_cmd), .node_detected(b_nd), .node_counter(b_nc),
    .lap_counter(b_lap), .finish(b_fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles on instance A, counting node_detected pulses.
  task automatic run_a(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (a_nd === 1'b1) cnt++;
    end
  endtask

  logic [3:0] b_exp_nc  [4];
  logic [1:0] b_exp_lap [4];

  initial begin
    b_exp_nc  = '{4'd1, 4'd0, 4'd1, 4'd0};
    b_exp_lap = '{2'd0, 2'd1, 2'd1, 2'd2};
    a_reset = 1'b1; a_start = 1'b0; a_ld = 3'b000;
    a_wr_en = 1'b0; a_wr_addr = 3'd0; a_wr_data = 2'd0;
    b_reset = 1'b1; b_start = 1'b1; b_ld = 3'b000;
    b_wr_en = 1'b0; b_wr_addr = 3'd0; b_wr_data = 2'd0;
    #1;
    chk("rst_cmd", {6'd0, a_cmd}, 8'h03);
    chk("rst_nd",  {7'd0, a_nd}, 8'h00);
    chk("rst_nc",  {4'd0, a_nc}, 8'h00);
    chk("rst_lap", {6'd0, a_lap}, 8'h00);
    chk("rst_fin", {7'd0, a_fin}, 8'h00);
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;

    // B: start held high through reset release must not start the run
    tick(); tick(); tick();
    chk("b_start_held", {6'd0, b_cmd}, 8'h03);
    b_start = 1'b0; tick();
    b_start = 1'b1; tick();
    chk("b_start_edge", {6'd0, b_cmd}, 8'h00);
    b_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_ld = 3'b111;
      tick(); tick(); tick(); tick();
      chk("b_node_pulse", {7'd0, b_nd}, 8'h01);
      chk("b_node_cnt", {4'd0, b_nc}, {4'd0, b_exp_nc[k]});
      chk("b_lap_cnt", {6'd0, b_lap}, {6'd0, b_exp_lap[k]});
      b_ld = 3'b000;
      if (k < 3) begin
        chk("b_not_fin", {7'd0, b_fin}, 8'h00);
        repeat (20) tick();
      end
    end
    chk("b_finish", {7'd0, b_fin}, 8'h01);
    chk("b_done_cmd", {6'd0, b_cmd}, 8'h03);
    b_start = 1'b0; tick();
    b_start = 1'b1; tick(); tick();
    chk("b_done_start_ign", {6'd0, b_cmd}, 8'h03);
    chk("b_done_fin_hold", {7'd0, b_fin}, 8'h01);

    // A run 1: start, node 0 turns right, TURN_MIN boundary
    a_start = 1'b1; tick();
    chk("a_start_cmd", {6'd0, a_cmd}, 8'h00);
    a_start = 1'b0;
    a_ld = 3'b111;
    tick(); tick(); tick();
    chk("a_confirm_early", {7'd0, a_nd}, 8'h00);
    tick();
    chk("a_n0_pulse", {7'd0, a_nd}, 8'h01);
    chk("a_n0_nc", {4'd0, a_nc}, 8'h01);
    chk("a_n0_cmd", {6'd0, a_cmd}, 8'h01);
    a_ld = 3'b010;
    tick(); tick(); tick(); tick();
    chk("a_turn_min", {6'd0, a_cmd}, 8'h01);
    tick();
    chk("a_turn_exit", {6'd0, a_cmd}, 8'h00);

    // 111 held through blanking: next event exactly NODE_CONFIRM cycles after BLANK ends
    a_ld = 3'b111;
    run_a(23, pulses);
    chk("a_blank1_quiet", 8'(pulses), 8'h00);
    chk("a_blank1_nc", {4'd0, a_nc}, 8'h01);
    tick();
    chk("a_n1_pulse", {7'd0, a_nd}, 8'h01);
    chk("a_n1_nc", {4'd0, a_nc}, 8'h02);
    chk("a_n1_cmd", {6'd0, a_cmd}, 8'h00);
    run_a(23, pulses);
    chk("a_blank2_quiet", 8'(pulses), 8'h00);
    tick();
    chk("a_n2_nc", {4'd0, a_nc}, 8'h03);
    chk("a_n2_cmd", {6'd0, a_cmd}, 8'h01);
    a_ld = 3'b010; repeat (5) tick();
    a_ld = 3'b000; repeat (20) tick();

    // Broken 111 run must not confirm a node
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      a_ld = (i == 3) ? 3'b010 : 3'b111;
      tick();
      if (a_nd === 1'b1) pulses++;
    end
    chk("a_glitch_quiet", 8'(pulses), 8'h00);
    chk("a_glitch_nc", {4'd0, a_nc}, 8'h03);
    tick();
    chk("a_n3_pulse", {7'd0, a_nd}, 8'h01);
    chk("a_n3_nc", {4'd0, a_nc}, 8'h04);
    a_ld = 3'b000; repeat (20) tick();
    a_ld = 3'b111; repeat (4) tick();
    chk("a_n4_cmd", {6'd0, a_cmd}, 8'h01);
    a_ld = 3'b000; tick(); tick();

    // Asynchronous reset while turning
    a_reset = 1'b1;
    #1;
    chk("a_mid_rst_cmd", {6'd0, a_cmd}, 8'h03);
    chk("a_mid_rst_nc", {4'd0, a_nc}, 8'h00);
    chk("a_mid_rst_lap", {6'd0, a_lap}, 8'h00);
    tick(); tick();
    a_reset = 1'b0;
    tick();

    // A run 2: write entry 1 = halt with the start edge; write during FOLLOW is dropped
    a_start = 1'b1; a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 2'b11;
    tick();
    chk("a_restart_cmd", {6'd0, a_cmd}, 8'h00);
    a_start = 1'b0; a_wr_addr = 3'd0; a_wr_data = 2'b00;
    tick();
    a_wr_en = 1'b0;
    a_ld = 3'b111; repeat (4) tick();
    chk("a_wr_drop_cmd", {6'd0, a_cmd}, 8'h01);
    chk("a_wr_drop_nc", {4'd0, a_nc}, 8'h01);
    a_ld = 3'b010; repeat (5) tick();
    a_ld = 3'b000; repeat (20) tick();
    a_ld = 3'b111; repeat (4) tick();
    chk("a_r2_n1_nc", {4'd0, a_nc}, 8'h02);
`ifdef NODE_ROUTE_WRITE_EN
    chk("a_wr_halt_cmd", {6'd0, a_cmd}, 8'h03);
    chk("a_wr_halt_fin", {7'd0, a_fin}, 8'h01);
`else
    chk("a_ro_n1_cmd", {6'd0, a_cmd}, 8'h00);
    chk("a_ro_n1_fin", {7'd0, a_fin}, 8'h00);
`endif

    // A run 3: reset restores the table, node 1 is straight again
    a_ld = 3'b000;
    a_reset = 1'b1; tick(); a_reset = 1'b0; tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_ld = 3'b111; repeat (4) tick();
    chk("a_r3_n0_cmd", {6'd0, a_cmd}, 8'h01);
    a_ld = 3'b010; repeat (5) tick();
    a_ld = 3'b000; repeat (20) tick();
    a_ld = 3'b111; repeat (4) tick();
    chk("a_r3_n1_cmd", {6'd0, a_cmd}, 8'h00);
    chk("a_r3_n1_fin", {7'd0, a_fin}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
